// File: rtl/kt_move_sched.sv
// Knight's-tour move scheduler: owns the visited bitmap and scans the eight
// knight directions one per cycle, returning the first legal unvisited move.
module kt_move_sched #(
  parameter int N         = 5,
  parameter bit AUTO_MARK = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [2:0] req_x,
  input  logic [2:0] req_y,
  input  logic [2:0] req_dir,
  input  logic       abort,
  output logic       rsp_valid,
  output logic       rsp_found,
  output logic [2:0] rsp_dir,
  output logic [2:0] rsp_x,
  output logic [2:0] rsp_y,
  output logic [3:0] rsp_tries,
  input  logic       mark_en,
  input  logic       unmark_en,
  input  logic [2:0] mark_x,
  input  logic [2:0] mark_y,
  input  logic       clr,
  output logic [5:0] visited_cnt,
  output logic       board_full
);

  localparam int         NN  = N * N;
  localparam logic [2:0] N3  = 3'(N);
  localparam logic [5:0] N6  = 6'(N);
  localparam logic [5:0] NN6 = 6'(NN);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t      state_q, state_d;
  logic [2:0]  cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic [2:0]  dir_ptr_q, dir_ptr_d;
  logic [3:0]  tries_q, tries_d;
  logic        rsp_valid_q, rsp_valid_d, rsp_found_q, rsp_found_d;
  logic [2:0]  rsp_dir_q, rsp_dir_d, rsp_x_q, rsp_x_d, rsp_y_q, rsp_y_d;
  logic [3:0]  rsp_tries_q, rsp_tries_d;
  // 64 bits so any 6-bit cell index is a valid select; cells >= N*N stay 0
  logic [63:0] bitmap_q, bitmap_d;
  logic [5:0]  visited_cnt_q, visited_cnt_d;
  logic        board_full_q, board_full_d;

  logic signed [3:0] dx, dy, dst_x, dst_y;
  logic [5:0]  dst_idx, mark_idx;
  logic        in_bounds, legal, pos_oob, mark_ok, auto_mark;
  logic [3:0]  tries_inc;

  always_comb begin
    dx = 4'sd0;
    dy = 4'sd0;
    case (dir_ptr_q)
      3'd0: begin dx = -4'sd1; dy =  4'sd2; end
      3'd1: begin dx =  4'sd1; dy =  4'sd2; end
      3'd2: begin dx =  4'sd2; dy =  4'sd1; end
      3'd3: begin dx =  4'sd2; dy = -4'sd1; end
      3'd4: begin dx =  4'sd1; dy = -4'sd2; end
      3'd5: begin dx = -4'sd1; dy = -4'sd2; end
      3'd6: begin dx = -4'sd2; dy = -4'sd1; end
      default: begin dx = -4'sd2; dy = 4'sd1; end
    endcase
  end

  assign dst_x     = $signed({1'b0, cur_x_q}) + dx;
  assign dst_y     = $signed({1'b0, cur_y_q}) + dy;
  assign in_bounds = !dst_x[3] && !dst_y[3] && (dst_x[2:0] < N3) && (dst_y[2:0] < N3);
  assign dst_idx   = N6 * {3'b000, dst_x[2:0]} + {3'b000, dst_y[2:0]};
  assign legal     = in_bounds && !bitmap_q[dst_idx];
  assign pos_oob   = (cur_x_q >= N3) || (cur_y_q >= N3);
  assign tries_inc = tries_q + 4'd1;

  assign mark_ok  = (mark_x < N3) && (mark_y < N3);
  assign mark_idx = N6 * {3'b000, mark_x} + {3'b000, mark_y};

  always_comb begin
    state_d     = state_q;
    cur_x_d     = cur_x_q;
    cur_y_d     = cur_y_q;
    dir_ptr_d   = dir_ptr_q;
    tries_d     = tries_q;
    rsp_valid_d = 1'b0;
    rsp_found_d = rsp_found_q;
    rsp_dir_d   = rsp_dir_q;
    rsp_x_d     = rsp_x_q;
    rsp_y_d     = rsp_y_q;
    rsp_tries_d = rsp_tries_q;
    auto_mark   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          cur_x_d   = req_x;
          cur_y_d   = req_y;
          dir_ptr_d = req_dir;
          tries_d   = 4'd0;
          state_d   = SCAN;
        end
      end
      default: begin
        if (abort) begin
          state_d = IDLE;
        end else if (pos_oob) begin
          // off-board origin: fail without scanning
          rsp_valid_d = 1'b1;
          rsp_found_d = 1'b0;
          rsp_dir_d   = dir_ptr_q;
          rsp_x_d     = 3'd0;
          rsp_y_d     = 3'd0;
          rsp_tries_d = 4'd0;
          state_d     = IDLE;
        end else begin
          tries_d = tries_inc;
          if (legal) begin
            rsp_valid_d = 1'b1;
            rsp_found_d = 1'b1;
            rsp_dir_d   = dir_ptr_q;
            rsp_x_d     = dst_x[2:0];
            rsp_y_d     = dst_y[2:0];
            rsp_tries_d = tries_inc;
            auto_mark   = AUTO_MARK;
            state_d     = IDLE;
          end else if (tries_inc == 4'd8) begin
            rsp_valid_d = 1'b1;
            rsp_found_d = 1'b0;
            rsp_dir_d   = dir_ptr_q;
            rsp_x_d     = 3'd0;
            rsp_y_d     = 3'd0;
            rsp_tries_d = tries_inc;
            state_d     = IDLE;
          end else begin
            dir_ptr_d = dir_ptr_q + 3'd1;
          end
        end
      end
    endcase
  end

  // later assignments win: unmark < mark/auto-mark, clr overrides all
  always_comb begin
    bitmap_d = bitmap_q;
    if (clr) begin
      bitmap_d = '0;
    end else begin
      if (unmark_en && mark_ok) bitmap_d[mark_idx] = 1'b0;
      if (mark_en && mark_ok)   bitmap_d[mark_idx] = 1'b1;
      if (auto_mark)            bitmap_d[dst_idx]  = 1'b1;
    end
    visited_cnt_d = '0;
    for (int i = 0; i < NN; i++) visited_cnt_d = visited_cnt_d + {5'b00000, bitmap_d[i]};
    board_full_d = (visited_cnt_d == NN6);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cur_x_q       <= '0;
      cur_y_q       <= '0;
      dir_ptr_q     <= '0;
      tries_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_found_q   <= 1'b0;
      rsp_dir_q     <= '0;
      rsp_x_q       <= '0;
      rsp_y_q       <= '0;
      rsp_tries_q   <= '0;
      bitmap_q      <= '0;
      visited_cnt_q <= '0;
      board_full_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_x_q       <= cur_x_d;
      cur_y_q       <= cur_y_d;
      dir_ptr_q     <= dir_ptr_d;
      tries_q       <= tries_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_found_q   <= rsp_found_d;
      rsp_dir_q     <= rsp_dir_d;
      rsp_x_q       <= rsp_x_d;
      rsp_y_q       <= rsp_y_d;
      rsp_tries_q   <= rsp_tries_d;
      bitmap_q      <= bitmap_d;
      visited_cnt_q <= visited_cnt_d;
      board_full_q  <= board_full_d;
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_found   = rsp_found_q;
  assign rsp_dir     = rsp_dir_q;
  assign rsp_x       = rsp_x_q;
  assign rsp_y       = rsp_y_q;
  assign rsp_tries   = rsp_tries_q;
  assign visited_cnt = visited_cnt_q;
  assign board_full  = board_full_q;

endmodule

// File: tb/tb_kt_move_sched.sv
// Scoreboard bench for kt_move_sched: directed requests push expected
// responses; a negedge monitor pops and compares every rsp_valid pulse.
module tb_kt_move_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid, req_ready;
  logic [2:0] req_x, req_y, req_dir;
  logic       abort;
  logic       rsp_valid, rsp_found;
  logic [2:0] rsp_dir, rsp_x, rsp_y;
  logic [3:0] rsp_tries;
  logic       mark_en, unmark_en, clr;
  logic [2:0] mark_x, mark_y;
  logic [5:0] visited_cnt;
  logic       board_full;

  kt_move_sched #(.N(5), .AUTO_MARK(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_dir(req_dir),
    .abort(abort),
    .rsp_valid(rsp_valid), .rsp_found(rsp_found), .rsp_dir(rsp_dir),
    .rsp_x(rsp_x), .rsp_y(rsp_y), .rsp_tries(rsp_tries),
    .mark_en(mark_en), .unmark_en(unmark_en), .mark_x(mark_x), .mark_y(mark_y),
    .clr(clr), .visited_cnt(visited_cnt), .board_full(board_full)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        found;
    logic [2:0]  dir;
    logic [2:0]  x;
    logic [2:0]  y;
    logic [3:0]  tries;
    logic [31:0] cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_rsp: got found=%0b dir=%0d (%0d,%0d) tries=%0d at cyc %0d, none expected",
                 rsp_found, rsp_dir, rsp_x, rsp_y, rsp_tries, cyc);
      end else begin
        exp_t e;
        exp_t a;
        e = exp_q.pop_front();
        a = '{rsp_found, rsp_dir, rsp_x, rsp_y, rsp_tries, 32'(cyc)};
        if (a !== e) begin
          n_err++;
          $display("FAIL rsp: got found=%0b dir=%0d (%0d,%0d) tries=%0d cyc=%0d, need found=%0b dir=%0d (%0d,%0d) tries=%0d cyc=%0d",
                   a.found, a.dir, a.x, a.y, a.tries, a.cyc, e.found, e.dir, e.x, e.y, e.tries, e.cyc);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, need %0d", name, act, exp);
    end
  endtask

  // drive one request; returns right after the accepting edge (+1)
  task automatic send(input logic [2:0] x, input logic [2:0] y, input logic [2:0] d);
    req_valid = 1'b1; req_x = x; req_y = y; req_dir = d;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic issue(input logic [2:0] x, input logic [2:0] y, input logic [2:0] d,
                       input logic ef, input logic [2:0] ed, input logic [2:0] ex,
                       input logic [2:0] ey, input logic [3:0] et);
    exp_t e;
    send(x, y, d);
    e = '{ef, ed, ex, ey, et, 32'(cyc + ((et == 4'd0) ? 1 : int'(et)))};
    exp_q.push_back(e);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      chk({name, "_timeout"}, exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic bm(input logic m, input logic u, input logic c,
                    input logic [2:0] x, input logic [2:0] y);
    @(negedge clk);
    mark_en = m; unmark_en = u; clr = c; mark_x = x; mark_y = y;
    @(posedge clk); #1;
    mark_en = 1'b0; unmark_en = 1'b0; clr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_x = '0; req_y = '0; req_dir = '0;
    abort = 1'b0; mark_en = 1'b0; unmark_en = 1'b0; clr = 1'b0;
    mark_x = '0; mark_y = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_cnt", visited_cnt, 0);
    chk("rst_full", board_full, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // empty board from (0,0) dir 0: dir 0 off-board, dir 1 -> (1,2)
    issue(3'd0, 3'd0, 3'd0, 1'b1, 3'd1, 3'd1, 3'd2, 4'd2);
    drain("t1");
    chk("t1_cnt", visited_cnt, 1);
    chk("t1_bit7", dut.bitmap_q[7], 1);

    // both in-board moves from (0,0) visited -> full fail, last dir 1
    bm(1'b1, 1'b0, 1'b0, 3'd2, 3'd1);
    bm(1'b1, 1'b0, 1'b0, 3'd1, 3'd2);
    @(negedge clk);
    chk("t2_cnt_pre", visited_cnt, 2);
    issue(3'd0, 3'd0, 3'd2, 1'b0, 3'd1, 3'd0, 3'd0, 4'd8);
    drain("t2");
    chk("t2_cnt", visited_cnt, 2);

    // back-to-back: second request accepted in the rsp_valid cycle
    bm(1'b0, 1'b0, 1'b1, 3'd0, 3'd0);
    @(negedge clk);
    chk("t3_clr_cnt", visited_cnt, 0);
    issue(3'd2, 3'd2, 3'd7, 1'b1, 3'd7, 3'd0, 3'd3, 4'd1);
    @(posedge clk); #1;
    chk("t3_rsp_cycle_valid", rsp_valid, 1);
    chk("t3_rsp_cycle_ready", req_ready, 1);
    issue(3'd4, 3'd4, 3'd0, 1'b1, 3'd5, 3'd3, 3'd2, 4'd6);
    drain("t3");
    chk("t3_cnt", visited_cnt, 2);

    // abort on the second scan edge
    bm(1'b0, 1'b0, 1'b1, 3'd0, 3'd0);
    @(negedge clk);
    send(3'd0, 3'd0, 3'd3);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("t4_ready", req_ready, 1);
    repeat (12) @(posedge clk);
    @(negedge clk);
    chk("t4_cnt", visited_cnt, 0);

    // bitmap write priorities
    bm(1'b1, 1'b1, 1'b0, 3'd1, 3'd1);
    @(negedge clk);
    chk("t5_mark_wins_cnt", visited_cnt, 1);
    chk("t5_bit6", dut.bitmap_q[6], 1);
    bm(1'b0, 1'b1, 1'b0, 3'd1, 3'd1);
    @(negedge clk);
    chk("t5_unmark_cnt", visited_cnt, 0);
    bm(1'b1, 1'b0, 1'b0, 3'd1, 3'd1);
    bm(1'b1, 1'b0, 1'b1, 3'd2, 3'd2);
    @(negedge clk);
    chk("t5_clr_wins_cnt", visited_cnt, 0);
    bm(1'b1, 1'b0, 1'b0, 3'd5, 3'd1);
    @(negedge clk);
    chk("t5_oob_mark_cnt", visited_cnt, 0);
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        bm(1'b1, 1'b0, 1'b0, 3'(x), 3'(y));
    @(negedge clk);
    chk("t5_full_cnt", visited_cnt, 25);
    chk("t5_full", board_full, 1);
    issue(3'd2, 3'd2, 3'd0, 1'b0, 3'd7, 3'd0, 3'd0, 4'd8);
    drain("t5_fullscan");
    issue(3'd5, 3'd0, 3'd4, 1'b0, 3'd4, 3'd0, 3'd0, 4'd0);
    drain("t5_oobreq");

    // async reset in the middle of a scan
    bm(1'b0, 1'b0, 1'b1, 3'd0, 3'd0);
    bm(1'b1, 1'b0, 1'b0, 3'd3, 3'd3);
    @(negedge clk);
    chk("t6_cnt_pre", visited_cnt, 1);
    send(3'd0, 3'd0, 3'd3);
    @(posedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("t6_ready", req_ready, 1);
    chk("t6_rsp_valid", rsp_valid, 0);
    chk("t6_cnt", visited_cnt, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    @(negedge clk);
    chk("t6_ready_after", req_ready, 1);
    chk("t6_bitmap", (dut.bitmap_q == 64'd0) ? 1 : 0, 1);
    chk("t6_no_pending", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
